// File: rtl/out_wrapper_pkg.sv
// ============================================================================
// Module   : out_wrapper_pkg
// Brief    : Shared types and widths for the FP result output wrapper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package out_wrapper_pkg;

  localparam int FLAG_W  = 5;
  localparam int WORD_W  = 32;
  localparam int ENTRY_W = FLAG_W + WORD_W;

  typedef enum logic [2:0] {
    Idle     = 3'd0,
    Load     = 3'd1,
    Offer0   = 3'd2,
    Release0 = 3'd3,
    Flag     = 3'd4,
    Offer1   = 3'd5,
    Release1 = 3'd6
  } state_e;

  typedef struct packed {
    logic [FLAG_W-1:0] flags;
    logic [WORD_W-1:0] result;
  } entry_t;

  function automatic logic is_offer(input state_e s);
    return (s == Offer0) || (s == Offer1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/out_wrapper_fifo.sv
// ============================================================================
// Module   : out_fifo
// Brief    : Power-of-two result FIFO with registered storage and occupancy count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module out_fifo #(
  parameter int DEPTH   = 4,
  parameter int ENTRY_W = 37
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [ENTRY_W-1:0]       din_i,
  output logic [ENTRY_W-1:0]       dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]      wr_ptr_q;
  logic [PW-1:0]      rd_ptr_q;
  logic [CW-1:0]      count_q;
  logic [CW-1:0]      count_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/out_wrapper_top.sv
// ============================================================================
// Module   : out_wrapper_top
// Brief    : Buffers FP results and flags, then sends them over a four-phase
//            outReady/outAccepted handshake on a shared 32-bit bus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module out_wrapper_top
  import out_wrapper_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter bit SEND_FLAGS = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              doneFP,
  input  logic [WORD_W-1:0] result,
  input  logic [FLAG_W-1:0] flags,
  input  logic              outAccepted,
  output logic [WORD_W-1:0] outBus,
  output logic              outReady,
  output logic              fifoFull,
  output logic              overflowErr
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_e            state_q;
  state_e            state_d;
  logic [WORD_W-1:0] outbus_q;
  logic [FLAG_W-1:0] flag_q;
  logic              ready_q;
  logic              ovf_q;

  entry_t            din;
  entry_t            head;
  logic [ENTRY_W-1:0] fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic              push;
  logic              pop;
  logic              drop;

  assign din  = {flags, result};
  assign head = entry_t'(fifo_dout);

  // A full FIFO still accepts a new entry on the edge that frees a slot.
  assign pop  = (state_q == Load);
  assign push = doneFP && (!fifo_full || pop);
  assign drop = doneFP && fifo_full && !pop;

  out_fifo #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (din),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      Idle:     if (!fifo_empty) state_d = Load;
      Load:     state_d = Offer0;
      Offer0:   if (outAccepted) state_d = Release0;
      Release0: if (!outAccepted) state_d = SEND_FLAGS ? Flag : Idle;
      Flag:     state_d = Offer1;
      Offer1:   if (outAccepted) state_d = Release1;
      Release1: if (!outAccepted) state_d = Idle;
      default:  state_d = Idle;
    endcase
  end

  // outReady is registered from the next state so it stays a clean Moore output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= Idle;
      outbus_q <= '0;
      flag_q   <= '0;
      ready_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= is_offer(state_d);
      if (state_q == Load) begin
        outbus_q <= head.result;
        flag_q   <= head.flags;
      end else if (state_q == Flag) begin
        outbus_q <= {{(WORD_W-FLAG_W){1'b0}}, flag_q};
      end
      if (drop) ovf_q <= 1'b1;
    end
  end

  assign outBus      = outbus_q;
  assign outReady    = ready_q;
  assign fifoFull    = (fifo_count == CW'(DEPTH));
  assign overflowErr = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_out_wrapper_top.sv
// Scoreboard bench: two wrapper instances (flags on / flags off) share clock and reset;
// stimulus pushes expected words, a negedge monitor pops them on each new offer.
`default_nettype none

module tb_out_wrapper_top;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        done1 = 0, acc1 = 0, rdy1, full1, ovf1;
  logic [31:0] res1 = 0, bus1;
  logic [4:0]  flg1 = 0;
  logic        done0 = 0, acc0 = 0, rdy0, full0, ovf0;
  logic [31:0] res0 = 0, bus0;
  logic [4:0]  flg0 = 0;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp1[$];
  logic [31:0] exp0[$];
  int mode1 = 0, mode0 = 0, dly1 = 0, dly0 = 0;

  out_wrapper_top #(.DEPTH(4), .SEND_FLAGS(1'b1)) u_f1 (
    .clk(clk), .rst(rst), .doneFP(done1), .result(res1), .flags(flg1),
    .outAccepted(acc1), .outBus(bus1), .outReady(rdy1), .fifoFull(full1),
    .overflowErr(ovf1)
  );

  out_wrapper_top #(.DEPTH(4), .SEND_FLAGS(1'b0)) u_f0 (
    .clk(clk), .rst(rst), .doneFP(done0), .result(res0), .flags(flg0),
    .outAccepted(acc0), .outBus(bus0), .outReady(rdy0), .fifoFull(full0),
    .overflowErr(ovf0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Consumer model: mode 0 holds ack low, 1 acks after dly cycles, 2 holds ack high.
  initial begin : cons1
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin acc1 = 0; cnt = 0; end
      else if (mode1 == 0) acc1 = 0;
      else if (mode1 == 2) acc1 = 1;
      else if (rdy1 && !acc1) begin
        if (cnt >= dly1) begin acc1 = 1; cnt = 0; end else cnt++;
      end else if (!rdy1) acc1 = 0;
    end
  end

  initial begin : cons0
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin acc0 = 0; cnt = 0; end
      else if (mode0 == 0) acc0 = 0;
      else if (mode0 == 2) acc0 = 1;
      else if (rdy0 && !acc0) begin
        if (cnt >= dly0) begin acc0 = 1; cnt = 0; end else cnt++;
      end else if (!rdy0) acc0 = 0;
    end
  end

  // Monitor: each rising outReady is one delivered word.
  initial begin : monitor
    logic prev1, prev0;
    logic [31:0] e;
    prev1 = 0; prev0 = 0;
    forever begin
      @(negedge clk);
      if (rst && rdy1 && !prev1) begin
        checks++;
        if (exp1.size() == 0) begin
          errors++;
          $display("FAIL mon_flags: unexpected word %h, required none", bus1);
        end else begin
          e = exp1.pop_front();
          if (bus1 !== e) begin
            errors++;
            $display("FAIL mon_flags: got %h required %h", bus1, e);
          end
        end
      end
      if (rst && rdy0 && !prev0) begin
        checks++;
        if (exp0.size() == 0) begin
          errors++;
          $display("FAIL mon_noflags: unexpected word %h, required none", bus0);
        end else begin
          e = exp0.pop_front();
          if (bus0 !== e) begin
            errors++;
            $display("FAIL mon_noflags: got %h required %h", bus0, e);
          end
        end
      end
      prev1 = rst && rdy1;
      prev0 = rst && rdy0;
    end
  end

  task automatic drv1(input logic v, input logic [31:0] r, input logic [4:0] f);
    @(negedge clk);
    done1 = v; res1 = r; flg1 = f;
  endtask

  task automatic drv0(input logic v, input logic [31:0] r, input logic [4:0] f);
    @(negedge clk);
    done0 = v; res0 = r; flg0 = f;
  endtask

  task automatic drain1(input int maxc);
    int n;
    n = 0;
    while ((exp1.size() != 0 || rdy1) && n < maxc) begin @(negedge clk); n++; end
    checks++;
    if (exp1.size() != 0 || rdy1) begin
      errors++;
      $display("FAIL drain_flags: %0d words pending, outReady=%b, required 0 and 0", exp1.size(), rdy1);
    end
  endtask

  task automatic drain0(input int maxc);
    int n;
    n = 0;
    while ((exp0.size() != 0 || rdy0) && n < maxc) begin @(negedge clk); n++; end
    checks++;
    if (exp0.size() != 0 || rdy0) begin
      errors++;
      $display("FAIL drain_noflags: %0d words pending, outReady=%b, required 0 and 0", exp0.size(), rdy0);
    end
  endtask

  task automatic wait_rdy0(input int maxc);
    int n;
    n = 0;
    while (!rdy0 && n < maxc) begin @(negedge clk); n++; end
    check("wait_offer_noflags", {31'b0, rdy0}, 32'd1);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int n;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready1", {31'b0, rdy1}, 32'd0);
    check("rst_bus1", bus1, 32'd0);
    check("rst_full1", {31'b0, full1}, 32'd0);
    check("rst_ovf1", {31'b0, ovf1}, 32'd0);
    check("rst_ready0", {31'b0, rdy0}, 32'd0);
    check("rst_bus0", bus0, 32'd0);
    @(posedge clk); #2 rst = 1;

    // Single result with flags word, consumer acks after 3 cycles
    mode1 = 1; dly1 = 3;
    drv1(1, 32'h3F80_0000, 5'b00001);
    exp1.push_back(32'h3F80_0000);
    exp1.push_back(32'h0000_0001);
    drv1(0, 32'h0, 5'h0);
    drain1(60);
    repeat (3) @(negedge clk);
    check("t2_idle_ready", {31'b0, rdy1}, 32'd0);
    check("t2_bus_held", bus1, 32'h0000_0001);

    // Latency and single-word send without flags
    mode0 = 1; dly0 = 0;
    drv0(1, 32'h4000_0000, 5'b10101);
    exp0.push_back(32'h4000_0000);
    @(posedge clk); #1;
    check("t3_lat_E", {31'b0, rdy0}, 32'd0);
    done0 = 0;
    @(posedge clk); #1;
    check("t3_lat_E1", {31'b0, rdy0}, 32'd0);
    @(posedge clk); #1;
    check("t3_lat_E2", {31'b0, rdy0}, 32'd1);
    drain0(40);
    repeat (10) @(negedge clk);
    check("t3_one_word_ready", {31'b0, rdy0}, 32'd0);

    // Reset in the middle of an offer
    mode1 = 0;
    drv1(1, 32'h4049_0FDB, 5'b00100);
    exp1.push_back(32'h4049_0FDB);
    drv1(0, 32'h0, 5'h0);
    n = 0;
    while (!rdy1 && n < 20) begin @(negedge clk); n++; end
    check("t1_offer", {31'b0, rdy1}, 32'd1);
    check("t1_bus", bus1, 32'h4049_0FDB);
    @(posedge clk); #3 rst = 0;
    #1;
    check("t1_ready", {31'b0, rdy1}, 32'd0);
    check("t1_bus_clr", bus1, 32'd0);
    check("t1_ovf", {31'b0, ovf1}, 32'd0);
    exp1.delete();
    exp0.delete();
    @(posedge clk); #2 rst = 1;

    // Burst into a stalled consumer, fifth result dropped
    mode0 = 0;
    drv0(1, 32'h0000_00A0, 5'h0);
    exp0.push_back(32'h0000_00A0);
    drv0(0, 32'h0, 5'h0);
    wait_rdy0(20);
    for (int i = 1; i <= 4; i++) begin
      drv0(1, 32'(i), 5'h0);
      exp0.push_back(32'(i));
    end
    @(posedge clk); #1;
    check("t4_full", {31'b0, full0}, 32'd1);
    check("t4_ovf_before", {31'b0, ovf0}, 32'd0);
    drv0(1, 32'h0000_0005, 5'h0);
    drv0(0, 32'h0, 5'h0);
    @(posedge clk); #1;
    check("t4_ovf_after", {31'b0, ovf0}, 32'd1);
    check("t4_full_after", {31'b0, full0}, 32'd1);
    mode0 = 1; dly0 = 2;
    drain0(300);
    repeat (5) @(negedge clk);
    check("t4_ovf_sticky", {31'b0, ovf0}, 32'd1);
    check("t4_not_full", {31'b0, full0}, 32'd0);
    @(posedge clk); #2 rst = 0;
    #1;
    check("t4_ovf_reset", {31'b0, ovf0}, 32'd0);
    @(posedge clk); #2 rst = 1;

    // Early ack: single-cycle offer, then no re-offer while ack stays high
    mode0 = 2;
    drv0(1, 32'h0000_00B0, 5'h0);
    exp0.push_back(32'h0000_00B0);
    @(posedge clk); #1;
    done0 = 0;
    @(posedge clk); #1;
    check("t6_E1", {31'b0, rdy0}, 32'd0);
    @(posedge clk); #1;
    check("t6_offer", {31'b0, rdy0}, 32'd1);
    @(posedge clk); #1;
    check("t6_release", {31'b0, rdy0}, 32'd0);
    drv0(1, 32'h11, 5'h0); exp0.push_back(32'h11);
    drv0(1, 32'h22, 5'h0); exp0.push_back(32'h22);
    drv0(1, 32'h33, 5'h0); exp0.push_back(32'h33);
    drv0(1, 32'h44, 5'h0); exp0.push_back(32'h44);
    drv0(0, 32'h0, 5'h0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("t6_no_reassert", {31'b0, rdy0}, 32'd0);
    end
    check("t5_full_pre", {31'b0, full0}, 32'd1);

    // Push on the same edge as the Load pop while full
    mode0 = 0;
    repeat (2) @(negedge clk);
    drv0(1, 32'h55, 5'h0);
    exp0.push_back(32'h55);
    @(posedge clk); #1;
    done0 = 0;
    check("t5_count4", {31'b0, full0}, 32'd1);
    check("t5_ovf", {31'b0, ovf0}, 32'd0);
    check("t5_offer", {31'b0, rdy0}, 32'd1);
    mode0 = 1; dly0 = 1;
    drain0(300);
    check("t5_ovf_final", {31'b0, ovf0}, 32'd0);

    drain1(10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
